line_mem_arbiter: RTL

- Shares the single 256-bit line-memory port between the instruction cache (line fill, read only) and the data cache (line fill and line writeback).
- Sits between both caches and the memory/bus interface.
- Serialises requests with round-robin arbitration and owns one outstanding memory transaction at a time.
- Returns fill data and a one-cycle ack to the granted cache.

---
 rtl/line_mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/line_mem_arbiter.sv
// Line-memory arbiter: shares one 256-bit memory port between the icache
// (fill only) and the dcache (fill and writeback). One transaction is in
// flight at a time; ties between the caches are broken round-robin.
module line_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned OFFSET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   // icache side
   input  logic [ADDR_WIDTH-1:0] ic_addr_i,
   input  logic                  ic_rd_i,
   output logic [LINE_WIDTH-1:0] ic_data_o,
   output logic                  ic_ack_o,
   // dcache side
   input  logic [ADDR_WIDTH-1:0] dc_addr_i,
   input  logic [LINE_WIDTH-1:0] dc_data_i,
   input  logic                  dc_rd_i,
   input  logic                  dc_we_i,
   output logic [LINE_WIDTH-1:0] dc_data_o,
   output logic                  dc_ack_o,
   // memory side
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [LINE_WIDTH-1:0] mem_data_o,
   output logic                  mem_rd_o,
   output logic                  mem_we_o,
   input  logic [LINE_WIDTH-1:0] mem_data_i,
   input  logic                  mem_ack_i,
   output logic [1:0]            grant_o
);

   typedef enum logic [1:0] {StIdle, StIcBusy, StDcBusy, StResp} state_e;

   localparam logic [ADDR_WIDTH-1:0] AlignMask = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
   localparam logic [1:0] GrantNone = 2'b00;
   localparam logic [1:0] GrantIc   = 2'b01;
   localparam logic [1:0] GrantDc   = 2'b10;

   state_e                state_q, state_d;
   // 1: dcache was granted last, so the icache wins the next tie
   logic                  last_dc_q, last_dc_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [LINE_WIDTH-1:0] mem_data_d, ic_data_d, dc_data_d;
   logic                  mem_rd_d, mem_we_d, ic_ack_d, dc_ack_d;
   logic [1:0]            grant_d;

   logic ic_req, dc_req, pick_ic, pick_dc;

   // Request decode and round-robin choice, only acted on in StIdle
   always_comb begin
      ic_req  = ic_rd_i;
      dc_req  = dc_rd_i | dc_we_i;
      pick_ic = ic_req & (~dc_req | last_dc_q);
      pick_dc = dc_req & (~ic_req | ~last_dc_q);
   end

   // Next-state and next-output logic; everything holds unless changed
   always_comb begin
      state_d    = state_q;
      last_dc_d  = last_dc_q;
      mem_addr_d = mem_addr_o;
      mem_data_d = mem_data_o;
      mem_rd_d   = mem_rd_o;
      mem_we_d   = mem_we_o;
      ic_data_d  = ic_data_o;
      dc_data_d  = dc_data_o;
      ic_ack_d   = 1'b0;
      dc_ack_d   = 1'b0;
      grant_d    = grant_o;
      unique case (state_q)
         StIdle: begin
            if (pick_ic) begin
               mem_addr_d = ic_addr_i & AlignMask;
               mem_rd_d   = 1'b1;
               grant_d    = GrantIc;
               last_dc_d  = 1'b0;
               state_d    = StIcBusy;
            end else if (pick_dc) begin
               mem_addr_d = dc_addr_i & AlignMask;
               // writeback takes priority over a simultaneous fill request
               mem_we_d   = dc_we_i;
               mem_rd_d   = ~dc_we_i;
               if (dc_we_i) mem_data_d = dc_data_i;
               grant_d    = GrantDc;
               last_dc_d  = 1'b1;
               state_d    = StDcBusy;
            end
         end
         StIcBusy: begin
            if (mem_ack_i) begin
               mem_rd_d  = 1'b0;
               mem_we_d  = 1'b0;
               ic_data_d = mem_data_i;
               ic_ack_d  = 1'b1;
               state_d   = StResp;
            end
         end
         StDcBusy: begin
            if (mem_ack_i) begin
               if (mem_rd_o) dc_data_d = mem_data_i;
               mem_rd_d = 1'b0;
               mem_we_d = 1'b0;
               dc_ack_d = 1'b1;
               state_d  = StResp;
            end
         end
         StResp: begin
            grant_d = GrantNone;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; reset aborts any transaction silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         last_dc_q  <= 1'b1;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         mem_rd_o   <= 1'b0;
         mem_we_o   <= 1'b0;
         ic_data_o  <= '0;
         dc_data_o  <= '0;
         ic_ack_o   <= 1'b0;
         dc_ack_o   <= 1'b0;
         grant_o    <= GrantNone;
      end else begin
         state_q    <= state_d;
         last_dc_q  <= last_dc_d;
         mem_addr_o <= mem_addr_d;
         mem_data_o <= mem_data_d;
         mem_rd_o   <= mem_rd_d;
         mem_we_o   <= mem_we_d;
         ic_data_o  <= ic_data_d;
         dc_data_o  <= dc_data_d;
         ic_ack_o   <= ic_ack_d;
         dc_ack_o   <= dc_ack_d;
         grant_o    <= grant_d;
      end
   end

endmodule
